// File: rtl/elastic_buffer.sv
// DEPTH-entry valid/ready elastic buffer with registered head, occupancy, flush and enable.
// Optional ELASTIC_BUFFER_STALL_COUNT_EN adds a saturating upstream-stall counter.
module elastic_buffer #(
    parameter int payload_width      = 64,
    parameter int depth              = 4,
    parameter int almost_full_margin = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [payload_width-1:0]   payload_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [payload_width-1:0]   payload_out,
    output logic [$clog2(depth+1)-1:0] level,
    output logic                       almost_full
`ifdef ELASTIC_BUFFER_STALL_COUNT_EN
    ,
    output logic [15:0]                stall_count
`endif
);

    localparam int LW = $clog2(depth + 1);
    localparam int PW = (depth > 2) ? $clog2(depth - 1) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(depth - 2);
    localparam logic [LW-1:0] LVL_FULL = LW'(depth);

    logic [payload_width-1:0] mem [0:depth-2];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic                     take_in;
    logic                     take_out;
    logic                     arr_empty;
    logic                     head_from_in;
    logic                     head_from_arr;
    logic                     arr_write;
    logic [LW-1:0]            level_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic af_of(input logic [LW-1:0] lvl);
        return (depth - int'(lvl)) <= almost_full_margin;
    endfunction

    assign in_ready = enable & (level != LVL_FULL);
    assign take_in  = in_valid & in_ready;
    assign take_out = enable & out_valid & out_ready;

    // The head is always occupied while anything is buffered, so level<=1 means the array is empty.
    assign arr_empty     = (level <= LW'(1));
    assign head_from_in  = take_in & (~out_valid | (take_out & arr_empty));
    assign head_from_arr = take_out & ~arr_empty;
    assign arr_write     = take_in & ~head_from_in;

    always_comb begin
        level_nxt = level;
        if (take_in && !take_out)
            level_nxt = level + 1'b1;
        else if (take_out && !take_in)
            level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_valid   <= 1'b0;
            level       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            almost_full <= af_of('0);
        end else begin
            level       <= level_nxt;
            almost_full <= af_of(level_nxt);
            if (head_from_in || head_from_arr)
                out_valid <= 1'b1;
            else if (take_out)
                out_valid <= 1'b0;
            if (head_from_arr)
                rd_ptr <= ptr_inc(rd_ptr);
            if (arr_write)
                wr_ptr <= ptr_inc(wr_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            payload_out <= '0;
        else if (!flush) begin
            if (head_from_in)
                payload_out <= payload_in;
            else if (head_from_arr)
                payload_out <= mem[rd_ptr];
        end
    end

    // Storage contents are deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!reset && !flush && arr_write)
            mem[wr_ptr] <= payload_in;
    end

`ifdef ELASTIC_BUFFER_STALL_COUNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush)
            stall_count <= '0;
        else if (enable && in_valid && !in_ready)
            stall_count <= sat_inc16(stall_count);
    end
`endif

endmodule

// File: tb/tb_elastic_buffer.sv
// Scoreboard bench for elastic_buffer: directed traffic at depth 4, random traffic at depth 3.
module tb_elastic_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en   [2];
    logic        fl   [2];
    logic        iv   [2];
    logic        ordy [2];
    logic [63:0] pin  [2];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D  = (g == 0) ? 4 : 3;
        localparam int LW = $clog2(D + 1);

        logic [LW-1:0] lvl;
        logic          ir;
        logic          ov;
        logic          af;
        logic [63:0]   pout;
        logic [63:0]   q[$];
        int            pops = 0;
`ifdef ELASTIC_BUFFER_STALL_COUNT_EN
        logic [15:0]   sc;
        int            sc_m = 0;
`endif

        elastic_buffer #(
            .payload_width(64),
            .depth(D),
            .almost_full_margin(1)
        ) u_dut (
            .clk(clk),
            .reset(rst),
            .enable(en[g]),
            .flush(fl[g]),
            .in_valid(iv[g]),
            .in_ready(ir),
            .payload_in(pin[g]),
            .out_valid(ov),
            .out_ready(ordy[g]),
            .payload_out(pout),
            .level(lvl),
            .almost_full(af)
`ifdef ELASTIC_BUFFER_STALL_COUNT_EN
            ,
            .stall_count(sc)
`endif
        );

        // Reference model: a plain FIFO queue of accepted words, updated once per clock.
        always @(negedge clk) begin
            int n;
            bit m_ready;
            if (rst) begin
                q.delete();
`ifdef ELASTIC_BUFFER_STALL_COUNT_EN
                sc_m = 0;
`endif
            end else begin
                n       = q.size();
                m_ready = en[g] && (n != D);
                chk($sformatf("d%0d level", D), 64'(lvl), 64'(n));
                chk($sformatf("d%0d almost_full", D), 64'(af), 64'((D - n) <= 1));
                chk($sformatf("d%0d in_ready", D), 64'(ir), 64'(m_ready));
                chk($sformatf("d%0d out_valid", D), 64'(ov), 64'(n > 0));
                if (n > 0)
                    chk($sformatf("d%0d payload_out", D), pout, q[0]);
`ifdef ELASTIC_BUFFER_STALL_COUNT_EN
                chk($sformatf("d%0d stall_count", D), 64'(sc), 64'(sc_m));
`endif
                if (fl[g]) begin
                    q.delete();
`ifdef ELASTIC_BUFFER_STALL_COUNT_EN
                    sc_m = 0;
`endif
                end else begin
`ifdef ELASTIC_BUFFER_STALL_COUNT_EN
                    if (en[g] && iv[g] && !m_ready && sc_m != 65535)
                        sc_m = sc_m + 1;
`endif
                    if (en[g] && n > 0 && ordy[g]) begin
                        void'(q.pop_front());
                        pops++;
                    end
                    if (iv[g] && m_ready)
                        q.push_back(pin[g]);
                end
            end
        end
    end

    initial begin
        logic [63:0] hold_p;
        int          budget;
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            en[g] = 1'b1; fl[g] = 1'b0; iv[g] = 1'b0; ordy[g] = 1'b0; pin[g] = '0;
        end
        repeat (2) cyc();
        rst = 1'b0;
        chk("reset payload_out", g_dut[0].pout, 64'h0);
        chk("reset level", 64'(g_dut[0].lvl), 64'd0);
        chk("reset almost_full", 64'(g_dut[0].af), 64'd0);
        chk("reset out_valid", 64'(g_dut[0].ov), 64'd0);

        // Fill with downstream stalled; the fifth word must be held upstream.
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1; pin[0] = 64'hA1 + 64'(i);
            cyc();
        end
        chk("full in_ready", 64'(g_dut[0].ir), 64'd0);
        chk("full level", 64'(g_dut[0].lvl), 64'd4);
        chk("full almost_full", 64'(g_dut[0].af), 64'd1);
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        cyc();
        chk("drain first", g_dut[0].pout, 64'hA2);
        repeat (5) cyc();
        chk("drained out_valid", 64'(g_dut[0].ov), 64'd0);
        chk("drained level", 64'(g_dut[0].lvl), 64'd0);

        // Continuous streaming: one word per cycle, occupancy pinned at one.
        for (int i = 0; i < 20; i++) begin
            iv[0] = 1'b1; pin[0] = 64'h100 + 64'(i);
            cyc();
            chk("stream payload", g_dut[0].pout, 64'h100 + 64'(i));
        end
        chk("stream level", 64'(g_dut[0].lvl), 64'd1);
        iv[0] = 1'b0;
        repeat (2) cyc();

        // Flush with a concurrent offer; the offered word is discarded.
        ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; pin[0] = 64'hB0 + 64'(i);
            cyc();
        end
        fl[0] = 1'b1; pin[0] = 64'hDEAD;
        cyc();
        fl[0] = 1'b0;
        chk("flush level", 64'(g_dut[0].lvl), 64'd0);
        chk("flush out_valid", 64'(g_dut[0].ov), 64'd0);
        pin[0] = 64'hF00D;
        cyc();
        iv[0] = 1'b0;
        chk("post-flush head", g_dut[0].pout, 64'hF00D);
        ordy[0] = 1'b1;
        repeat (2) cyc();

        // Enable held low mid-stream: everything must freeze.
        for (int i = 0; i < 10; i++) begin
            iv[0] = 1'b1; pin[0] = {$urandom, $urandom};
            if (i == 4) begin
                en[0] = 1'b0;
                hold_p = g_dut[0].pout;
                for (int k = 0; k < 5; k++) begin
                    cyc();
                    chk("enable-low payload", g_dut[0].pout, hold_p);
                    chk("enable-low in_ready", 64'(g_dut[0].ir), 64'd0);
                end
                en[0] = 1'b1;
            end
            cyc();
        end
        iv[0] = 1'b0;
        repeat (3) cyc();

        // Random traffic at a non-power-of-two depth.
        budget = 0;
        while (g_dut[1].pops < 1000 && budget < 20000) begin
            iv[1]   = ($urandom % 4) != 0;
            pin[1]  = {$urandom, $urandom};
            ordy[1] = ($urandom % 2) != 0;
            en[1]   = ($urandom % 8) != 0;
            cyc();
            budget++;
        end
        chk("random words delivered", 64'(g_dut[1].pops >= 1000), 64'd1);
        iv[1] = 1'b0;
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
